// File: rtl/hdlc_rx_drain.sv
// Drains received frames out of the Hdlc controller's RX buffer onto a byte stream.
// Errored or badly sized frames are released without being streamed.
module hdlc_rx_drain #(
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MAX_LEN      = 126,
  parameter int unsigned FCS_EN       = 1,
  parameter int unsigned ADDR_RX_SC   = 2,
  parameter int unsigned ADDR_RX_BUFF = 3,
  parameter int unsigned ADDR_RX_LEN  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic [ADDR_W-1:0] Address,
  output logic              WriteEnable,
  output logic              ReadEnable,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              Rx_Ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              frm_done,
  output logic [3:0]        frm_status,
  output logic [7:0]        frm_len,
  output logic              busy
);

  localparam logic [DATA_W-1:0] ScInit = DATA_W'(FCS_EN << 5);
  localparam logic [DATA_W-1:0] ScDrop = ScInit | DATA_W'(2);

  typedef enum logic [3:0] {
    StInit, StIdle, StRdSc, StWtSc, StRdLen, StWtLen,
    StRdByte, StWtByte, StOut, StDrop, StDone
  } state_e;

  state_e r_state, w_state_d;

  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [DATA_W-1:0] r_din, w_din_d;
  logic              r_we, w_we_d;
  logic              r_re, w_re_d;
  logic [7:0]        r_mdata;
  logic              r_valid, r_last, r_done, r_busy;
  logic [3:0]        r_status;
  logic [7:0]        r_len, r_cnt;
  logic              w_len_bad;

  assign w_len_bad = (DataOut == '0) || (DataOut > DATA_W'(MAX_LEN));

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= StInit;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StInit:   w_state_d = StIdle;
      StIdle:   if (Rx_Ready) w_state_d = StRdSc;
      StRdSc:   w_state_d = StWtSc;
      StWtSc:   w_state_d = (|DataOut[4:2]) ? StDrop : StRdLen;
      StRdLen:  w_state_d = StWtLen;
      StWtLen:  w_state_d = w_len_bad ? StDrop : StRdByte;
      StRdByte: w_state_d = StWtByte;
      StWtByte: w_state_d = StOut;
      StOut:    if (m_ready) w_state_d = r_last ? StDrop : StRdByte;
      StDrop:   w_state_d = StDone;
      StDone:   if (!Rx_Ready) w_state_d = StIdle;
      default:  w_state_d = StInit;
    endcase
  end

  // Bus strobes are registered off the next state so they line up with the
  // state that owns them; the INIT write lands in the first cycle after INIT.
  always_comb begin
    w_we_d   = 1'b0;
    w_re_d   = 1'b0;
    w_addr_d = '0;
    w_din_d  = '0;
    if (r_state == StInit) begin
      w_we_d   = 1'b1;
      w_addr_d = ADDR_W'(ADDR_RX_SC);
      w_din_d  = ScInit;
    end else begin
      case (w_state_d)
        StRdSc: begin
          w_re_d   = 1'b1;
          w_addr_d = ADDR_W'(ADDR_RX_SC);
        end
        StRdLen: begin
          w_re_d   = 1'b1;
          w_addr_d = ADDR_W'(ADDR_RX_LEN);
        end
        StRdByte: begin
          w_re_d   = 1'b1;
          w_addr_d = ADDR_W'(ADDR_RX_BUFF);
        end
        StDrop: begin
          w_we_d   = 1'b1;
          w_addr_d = ADDR_W'(ADDR_RX_SC);
          w_din_d  = ScDrop;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_mdata  <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_status <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
    end else begin
      r_we   <= w_we_d;
      r_re   <= w_re_d;
      r_addr <= w_addr_d;
      r_din  <= w_din_d;
      r_done <= (r_state == StDrop);
      r_busy <= (w_state_d != StIdle);
      case (r_state)
        StIdle: begin
          if (Rx_Ready) begin
            r_status <= '0;
            r_cnt    <= '0;
          end
        end
        StWtSc: r_status[2:0] <= DataOut[4:2];
        StWtLen: begin
          r_len <= DataOut[7:0];
          r_cnt <= '0;
          if (w_len_bad) r_status[3] <= 1'b1;
        end
        StWtByte: begin
          r_mdata <= DataOut[7:0];
          r_valid <= 1'b1;
          r_last  <= (r_cnt == r_len - 8'd1);
        end
        StOut: begin
          if (m_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Address     = r_addr;
  assign WriteEnable = r_we;
  assign ReadEnable  = r_re;
  assign DataIn      = r_din;
  assign m_data      = r_mdata;
  assign m_valid     = r_valid;
  assign m_last      = r_last;
  assign frm_done    = r_done;
  assign frm_status  = r_status;
  assign frm_len     = r_cnt;
  assign busy        = r_busy;

endmodule

// File: tb/tb_hdlc_rx_drain.sv
// Bench for hdlc_rx_drain: an Hdlc RX register model feeds frames, a monitor records
// bus, stream and status traffic, and per-frame expectations come from the frame itself.
module tb_hdlc_rx_drain;

  logic       Clk;
  logic       Rst;
  logic [2:0] Address;
  logic       WriteEnable, ReadEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut = 8'h00;
  logic       Rx_Ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_last, frm_done;
  logic [3:0] frm_status;
  logic [7:0] frm_len;
  logic       busy;

  hdlc_rx_drain u_dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Address    (Address),
    .WriteEnable(WriteEnable),
    .ReadEnable (ReadEnable),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .Rx_Ready   (Rx_Ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .frm_done   (frm_done),
    .frm_status (frm_status),
    .frm_len    (frm_len),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame currently presented by the Hdlc model
  logic [7:0] f_sc;
  int         f_len;
  logic [7:0] f_bytes[$];
  int         buf_idx = 0;

  // Monitor records
  logic [2:0]  rd_q[$];
  logic [15:0] wr_q[$];
  logic [8:0]  beat_q[$];
  logic [11:0] done_q[$];
  int          viol = 0;
  int          hold_3c = 0;
  int          rdy_mode = 0;
  int          stall_left = 0;
  logic        prev_re = 1'b0;
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [7:0]  prev_d = 8'h00;

  always @(negedge Clk) begin
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (m_valid && beat_q.size() == 1 && stall_left > 0) begin
          m_ready = 1'b0;
          stall_left--;
        end else begin
          m_ready = 1'b1;
        end
      end
    endcase
    // Hdlc register model: read data valid the cycle after the strobe, garbage otherwise
    if (ReadEnable) begin
      rd_q.push_back(Address);
      case (Address)
        3'd2: DataOut = f_sc;
        3'd4: DataOut = 8'(f_len);
        3'd3: begin
          DataOut = (buf_idx < f_bytes.size()) ? f_bytes[buf_idx] : 8'h00;
          buf_idx++;
        end
        default: DataOut = 8'($urandom);
      endcase
    end else if (!prev_re) begin
      DataOut = 8'($urandom);
    end
    prev_re = ReadEnable;
    if (WriteEnable) wr_q.push_back({5'b0, Address, DataIn});
    if (WriteEnable && ReadEnable) viol++;
    if (!WriteEnable && !ReadEnable && (Address != 3'd0 || DataIn != 8'd0)) viol++;
    if (ReadEnable && m_valid) viol++;
    if (prev_v && !prev_r && (!m_valid || m_data != prev_d || m_last != prev_l)) viol++;
    if (m_valid && m_ready) beat_q.push_back({m_last, m_data});
    if (frm_done) done_q.push_back({frm_status, frm_len});
    if (m_valid && m_data == 8'h3C) hold_3c++;
    prev_v = m_valid;
    prev_r = m_ready;
    prev_d = m_data;
    prev_l = m_last;
  end

  task automatic clear_records();
    rd_q.delete();
    wr_q.delete();
    beat_q.delete();
    done_q.delete();
    viol    = 0;
    hold_3c = 0;
    buf_idx = 0;
  endtask

  task automatic wait_done(input string tag);
    int budget = 0;
    while (done_q.size() == 0 && budget < 4000) begin
      @(negedge Clk);
      budget++;
    end
    check_eq({tag, ".done_seen"}, 32'(done_q.size() != 0), 32'd1);
    Rx_Ready = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  // Expected traffic derived from the frame contents alone
  task automatic check_frame(input string tag, input logic [15:0] exp_wr0, input int n_wr);
    logic       err, bad, good;
    logic [3:0] st;
    logic [2:0] exp_rd[$];
    int         n_beats;
    err  = |f_sc[4:2];
    bad  = !err && (f_len == 0 || f_len > 126);
    good = !err && !bad;
    st   = {bad, f_sc[4:2]};
    n_beats = good ? f_len : 0;
    exp_rd.push_back(3'd2);
    if (!err) exp_rd.push_back(3'd4);
    for (int i = 0; i < n_beats; i++) exp_rd.push_back(3'd3);
    check_eq({tag, ".rd_count"}, 32'(rd_q.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      check_eq({tag, ".rd_addr"}, 32'(rd_q[i]), 32'(exp_rd[i]));
    check_eq({tag, ".wr_count"}, 32'(wr_q.size()), 32'(n_wr));
    if (wr_q.size() == n_wr) begin
      if (n_wr == 2) check_eq({tag, ".wr_init"}, 32'(wr_q[0]), 32'(exp_wr0));
      check_eq({tag, ".wr_drop"}, 32'(wr_q[n_wr-1]), 32'h0222);
    end
    check_eq({tag, ".beat_count"}, 32'(beat_q.size()), 32'(n_beats));
    for (int i = 0; i < n_beats && i < beat_q.size(); i++)
      check_eq({tag, ".beat"}, 32'(beat_q[i]), 32'({(i == n_beats - 1), f_bytes[i]}));
    check_eq({tag, ".done_count"}, 32'(done_q.size()), 32'd1);
    if (done_q.size() != 0)
      check_eq({tag, ".status_len"}, 32'(done_q[0]), 32'({st, 8'(n_beats)}));
    check_eq({tag, ".bus_rules"}, 32'(viol), 32'd0);
    check_eq({tag, ".busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input string tag);
    clear_records();
    Rx_Ready = 1'b1;
    wait_done(tag);
    check_frame(tag, 16'h0000, 1);
  endtask

  task automatic set_frame(input logic [7:0] sc, input int len);
    f_sc  = sc;
    f_len = len;
    f_bytes.delete();
    if (len >= 1 && len <= 126)
      for (int i = 0; i < len; i++) f_bytes.push_back(8'($urandom));
  endtask

  initial begin
    int budget;
    Rst      = 1'b1;
    Rx_Ready = 1'b0;
    f_sc     = 8'h00;
    f_len    = 0;
    repeat (3) @(negedge Clk);
    check_eq("reset.bus", 32'({Address, WriteEnable, ReadEnable, DataIn}), 32'd0);
    check_eq("reset.stream", 32'({m_data, m_valid, m_last, frm_done, frm_status, frm_len, busy}),
             32'd0);
    clear_records();
    Rst = 1'b0;
    repeat (25) @(negedge Clk);
    check_eq("init.wr_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() != 0) check_eq("init.wr", 32'(wr_q[0]), 32'h0220);
    check_eq("init.rd_count", 32'(rd_q.size()), 32'd0);
    check_eq("init.busy", 32'(busy), 32'd0);
    check_eq("init.bus_rules", 32'(viol), 32'd0);

    rdy_mode = 0;
    set_frame(8'h21, 3);
    f_bytes[0] = 8'hA5; f_bytes[1] = 8'h3C; f_bytes[2] = 8'h7E;
    run_frame("good3");

    rdy_mode   = 2;
    stall_left = 5;
    run_frame("stall3");
    check_eq("stall3.hold_cycles", 32'(hold_3c), 32'd6);

    rdy_mode = 0;
    set_frame(8'h25, 3);
    run_frame("sc_err");
    set_frame(8'h21, 0);
    run_frame("len0");
    set_frame(8'h21, 127);
    run_frame("len127");
    set_frame(8'h21, 126);
    run_frame("len126");

    // Reset after the first beat of a 4-byte frame
    set_frame(8'h21, 4);
    clear_records();
    Rx_Ready = 1'b1;
    budget   = 0;
    while (beat_q.size() == 0 && budget < 2000) begin
      @(negedge Clk);
      budget++;
    end
    check_eq("midrst.first_beat", 32'(beat_q.size()), 32'd1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check_eq("midrst.bus", 32'({Address, WriteEnable, ReadEnable, DataIn}), 32'd0);
    check_eq("midrst.stream",
             32'({m_data, m_valid, m_last, frm_done, frm_status, frm_len, busy}), 32'd0);
    clear_records();
    wait_done("midrst");
    check_frame("midrst", 16'h0220, 2);

    rdy_mode = 1;
    for (int n = 0; n < 12; n++) begin
      int         r;
      logic [7:0] sc;
      sc = 8'($urandom) & 8'hE3;
      if ($urandom_range(0, 3) == 0) sc[3'($urandom_range(2, 4))] = 1'b1;
      r = $urandom_range(0, 9);
      if (r == 0)      set_frame(sc, 0);
      else if (r == 1) set_frame(sc, $urandom_range(127, 255));
      else             set_frame(sc, $urandom_range(1, 20));
      run_frame($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_drain.md
Name: hdlc_rx_drain

Overview:
Bus master that sits directly downstream of the Hdlc controller's RX side, on its register interface (Address/WriteEnable/ReadEnable/DataIn/DataOut, Rx_Ready).
- On Rx_Ready it reads Rx_SC, then Rx_Len, then drains the RX buffer byte by byte.
- Good frames are presented on a valid/ready byte stream with a last flag, followed by a per-frame status pulse.
- Errored frames are dropped without streaming. Every frame is released via Rx_Drop.

Parameters:
ADDR_W, 3, Hdlc register address width
DATA_W, 8, Hdlc data width
MAX_LEN, 126, largest legal Rx_Len value
FCS_EN, 1, value written to Rx_SC bit5 (Rx_FCSen) at init
ADDR_RX_SC, 2, Rx_SC address
ADDR_RX_BUFF, 3, RX buffer address
ADDR_RX_LEN, 4, Rx_Len address

Ports:
Clk  in  1  clock
Rst  in  1  synchronous, active-high reset
Address  out  ADDR_W  Hdlc register address
WriteEnable  out  1  Hdlc write strobe
ReadEnable  out  1  Hdlc read strobe
DataIn  out  DATA_W  write data to Hdlc
DataOut  in  DATA_W  read data from Hdlc
Rx_Ready  in  1  Hdlc frame-ready flag
m_data  out  8  stream byte
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_last  out  1  final byte of frame
frm_done  out  1  one-cycle frame-complete pulse
frm_status  out  4  [0] frame error, [1] abort, [2] overflow, [3] bad length
frm_len  out  8  bytes streamed for the frame
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (Clk edge with Rst=1):
  - All outputs 0; state INIT; byte counter 0.
  - Reset is honoured in any state, including mid-stream; the partial frame is abandoned and INIT runs again.
- Bus rules:
  - At most one of WriteEnable/ReadEnable high in a cycle; each strobe is exactly one cycle wide.
  - Address/DataIn are valid in the strobe cycle; Address=0 and DataIn=0 otherwise.
  - Read latency is 1: DataOut is sampled the cycle after ReadEnable.
- FSM:
  - INIT: write Rx_SC = FCS_EN<<5 -> IDLE.
  - IDLE: wait for Rx_Ready=1 -> RD_SC.
  - RD_SC: ReadEnable at ADDR_RX_SC -> WT_SC.
  - WT_SC: latch frm_status[2:0] = {DataOut[4], DataOut[3], DataOut[2]}.
    - Any bit set -> DROP.
    - Else -> RD_LEN.
  - RD_LEN: ReadEnable at ADDR_RX_LEN -> WT_LEN.
  - WT_LEN: latch len = DataOut.
    - len==0 or len>MAX_LEN -> set frm_status[3] -> DROP.
    - Else cnt=0 -> RD_BYTE.
  - RD_BYTE: ReadEnable at ADDR_RX_BUFF -> WT_BYTE.
  - WT_BYTE: m_data=DataOut; m_valid=1; m_last=(cnt==len-1) -> OUT.
  - OUT: hold m_data/m_valid/m_last stable until m_ready=1. On the handshake cycle:
    - m_valid drops next cycle; cnt++.
    - If m_last -> DROP.
    - Else -> RD_BYTE.
    - No new ReadEnable is issued while m_valid=1.
  - DROP: write Rx_SC = (FCS_EN<<5)|0x02 (release) -> DONE.
  - DONE:
    - frm_done=1 for exactly one cycle in the first DONE cycle.
    - frm_len = cnt (0 for errored frames); frm_status is valid while frm_done=1.
    - Stay until Rx_Ready=0, then -> IDLE.
    - This prevents re-reading a frame Hdlc has not yet cleared.
- Timing: minimum per byte is 3 cycles (RD_BYTE, WT_BYTE, OUT with m_ready=1).
- Counters: cnt is 8 bits and never exceeds MAX_LEN.
- A Rx_Ready change during a frame is ignored until DONE.
- frm_status is cleared on entry to RD_SC.

Test Plan:
- Reset released, Rx_Ready=0 -> exactly one write: Address=2, DataIn=0x20; then no strobes for 20 cycles; busy=0.
- Rx_Ready=1, Rx_SC read=0x21, Rx_Len=3, buffer reads 0xA5, 0x3C, 0x7E, m_ready=1 -> beats A5, 3C, 7E with m_last only on 7E. Then write Address=2, DataIn=0x22; frm_done pulse with frm_len=3, frm_status=0.
- Same frame with m_ready=0 for 5 cycles on the 0x3C beat -> m_valid/m_data=0x3C held 5 cycles; no ReadEnable in that window; output order unchanged.
- Rx_SC read=0x25 -> no Rx_Len or buffer reads; m_valid never high; drop write 0x22; frm_status=0x1, frm_len=0.
- Rx_Len=0, then a second frame with Rx_Len=127 -> no buffer reads for either; each frame gets a drop write and frm_status=0x8.
- Rst=1 for one cycle after the first beat of a 4-byte frame -> all outputs 0 next cycle. Then the INIT write repeats; if Rx_Ready is still 1 the frame is re-read from RD_SC.
